// File: rtl/fp_arith_pkg.sv
// Shared floating-point arithmetic types: exponent width, exponent type and the
// 4-bit carry-lookahead group result bundle.
package fp_arith_pkg;

  localparam int EXP_W             = 8;
  localparam int SHIFT_MAX_DEFAULT = 27;

  typedef logic [EXP_W-1:0] exp_t;

  typedef struct packed {
    logic [3:0] sum;
    logic       gg;
    logic       gp;
    logic       cout;
  } cla4_t;

endpackage

// File: rtl/cla4_block.sv
// Purely combinational 4-bit carry-lookahead group: per-bit generate/propagate,
// group generate/propagate and lookahead carry out.
module cla4_block
  import fp_arith_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output cla4_t      res
);

  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [3:0] c_s;

  // Every carry is expanded from g/p/cin directly so no carry waits on another.
  always_comb begin
    g_s    = a & b;
    p_s    = a ^ b;
    c_s[0] = cin;
    c_s[1] = g_s[0] | (p_s[0] & cin);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & cin);
    res.sum  = p_s ^ c_s;
    res.gg   = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
             | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
    res.gp   = &p_s;
    res.cout = res.gg | (res.gp & cin);
  end

endmodule

// File: rtl/exponent_subtractor.sv
// Two-stage pipelined exponent subtractor: |A-B|, swap flag and equality flag.
// Optional alignment-shift clamp is enabled by defining EXP_SUB_CLAMP_EN.
module exponent_subtractor
  import fp_arith_pkg::*;
#(
  parameter int WIDTH     = EXP_W,
  parameter int SHIFT_MAX = SHIFT_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_exp,
  input  logic [WIDTH-1:0] b_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             a_lt_b,
  output logic             eq,
  output logic             sat
);

  localparam int NG   = WIDTH / 4;
  localparam int LO_G = NG / 2;
  localparam int HI_G = NG - LO_G;
  localparam int LO_W = LO_G * 4;
  localparam int HI_W = HI_G * 4;

  if ((WIDTH % 4 != 0) || (WIDTH < 8) || (SHIFT_MAX < 0)) begin : g_param_err
    $error("exponent_subtractor: WIDTH must be a multiple of 4 and >= 8");
  end

  logic             adv2_s;
  logic             in_fire_s;
  logic [WIDTH-1:0] nb_s;
  logic [LO_W-1:0]  lo_sum_s;
  logic [HI_W-1:0]  hi_sum_s;
  logic [WIDTH-1:0] raw_s;
  logic [WIDTH-1:0] inv_raw_s;
  logic [WIDTH-1:0] neg_s;
  logic             c_mid_s;
  logic             cout_s;
  logic             raw_zero_s;
  logic             lt_s;
  logic [WIDTH-1:0] mag_s;
  logic [WIDTH-1:0] diff_nx_s;
  logic             sat_nx_s;

  logic             s1_valid_r;
  logic [LO_W-1:0]  s1_lo_sum_r;
  logic             s1_c_r;
  logic [HI_W-1:0]  s1_a_hi_r;
  logic [HI_W-1:0]  s1_nb_hi_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] diff_r;
  logic             a_lt_b_r;
  logic             eq_r;
  logic             sat_r;

  assign nb_s      = ~b_exp;
  assign adv2_s    = ~out_valid_r | out_ready;
  assign in_ready  = ~s1_valid_r | adv2_s;
  assign in_fire_s = in_valid & in_ready;

  // Low groups of A + ~B + 1, carry-in of one injected at group 0.
  for (genvar i = 0; i < LO_G; i++) begin : g_lo
    cla4_t res_s;
    logic  c_in_s;
    logic  unused_gp_s;
    if (i == 0) begin : g_first
      assign c_in_s = 1'b1;
    end else begin : g_next
      assign c_in_s = g_lo[i-1].res_s.cout;
    end
    cla4_block u_cla (.a(a_exp[4*i +: 4]), .b(nb_s[4*i +: 4]), .cin(c_in_s), .res(res_s));
    assign lo_sum_s[4*i +: 4] = res_s.sum;
    assign unused_gp_s        = res_s.gg ^ res_s.gp;
  end
  assign c_mid_s = g_lo[LO_G-1].res_s.cout;

  // Upper groups finish the subtraction from the registered mid carry.
  for (genvar i = 0; i < HI_G; i++) begin : g_hi
    cla4_t res_s;
    logic  c_in_s;
    logic  unused_gp_s;
    if (i == 0) begin : g_first
      assign c_in_s = s1_c_r;
    end else begin : g_next
      assign c_in_s = g_hi[i-1].res_s.cout;
    end
    cla4_block u_cla (.a(s1_a_hi_r[4*i +: 4]), .b(s1_nb_hi_r[4*i +: 4]), .cin(c_in_s), .res(res_s));
    assign hi_sum_s[4*i +: 4] = res_s.sum;
    assign unused_gp_s        = res_s.gg ^ res_s.gp;
  end
  assign cout_s    = g_hi[HI_G-1].res_s.cout;
  assign raw_s     = {hi_sum_s, s1_lo_sum_r};
  assign inv_raw_s = ~raw_s;

  // Negation ~raw + 1; its final carry out is set exactly when raw is zero.
  for (genvar i = 0; i < NG; i++) begin : g_neg
    cla4_t res_s;
    logic  c_in_s;
    logic  unused_gp_s;
    if (i == 0) begin : g_first
      assign c_in_s = 1'b1;
    end else begin : g_next
      assign c_in_s = g_neg[i-1].res_s.cout;
    end
    cla4_block u_cla (.a(inv_raw_s[4*i +: 4]), .b(4'b0000), .cin(c_in_s), .res(res_s));
    assign neg_s[4*i +: 4] = res_s.sum;
    assign unused_gp_s     = res_s.gg ^ res_s.gp;
  end
  assign raw_zero_s = g_neg[NG-1].res_s.cout;

`ifdef EXP_SUB_CLAMP_EN
  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(SHIFT_MAX);
`endif

  // Stage S2 result: magnitude select and optional clamp.
  always_comb begin
    lt_s = ~cout_s;
    if (lt_s) begin
      mag_s = neg_s;
    end else begin
      mag_s = raw_s;
    end
`ifdef EXP_SUB_CLAMP_EN
    if (mag_s > SHIFT_LIM) begin
      diff_nx_s = SHIFT_LIM;
      sat_nx_s  = 1'b1;
    end else begin
      diff_nx_s = mag_s;
      sat_nx_s  = 1'b0;
    end
`else
    diff_nx_s = mag_s;
    sat_nx_s  = 1'b0;
`endif
  end

  // Stage S1 register: low sums, mid carry and raw upper operand bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_lo_sum_r <= {LO_W{1'b0}};
      s1_c_r      <= 1'b0;
      s1_a_hi_r   <= {HI_W{1'b0}};
      s1_nb_hi_r  <= {HI_W{1'b0}};
    end else if (in_fire_s) begin
      s1_valid_r  <= 1'b1;
      s1_lo_sum_r <= lo_sum_s;
      s1_c_r      <= c_mid_s;
      s1_a_hi_r   <= a_exp[WIDTH-1:LO_W];
      s1_nb_hi_r  <= nb_s[WIDTH-1:LO_W];
    end else if (adv2_s) begin
      s1_valid_r  <= 1'b0;
    end
  end

  // Stage S2 output register; data only moves when a real entry advances.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      diff_r      <= {WIDTH{1'b0}};
      a_lt_b_r    <= 1'b0;
      eq_r        <= 1'b0;
      sat_r       <= 1'b0;
    end else if (adv2_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        diff_r   <= diff_nx_s;
        a_lt_b_r <= lt_s;
        eq_r     <= raw_zero_s;
        sat_r    <= sat_nx_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign a_lt_b    = a_lt_b_r;
  assign eq        = eq_r;
  assign sat       = sat_r;

endmodule

// File: doc/exponent_subtractor.md
EXPONENT_SUBTRACTOR -- requirements
Module: exponent_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, exponent width in bits; SHALL be a multiple of 4.
REQ-002 Parameter SHIFT_MAX, default 27, alignment-shift ceiling used only under clamp (REQ-021).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a_exp  input  WIDTH  biased exponent of operand A.
REQ-008 b_exp  input  WIDTH  biased exponent of operand B.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 diff  output  WIDTH  magnitude |A-B|, clamped when REQ-021 applies.
REQ-012 a_lt_b  output  1  A < B, so the mantissa swap is required.
REQ-013 eq  output  1  A == B.
REQ-014 sat  output  1  diff was clamped; constant 0 when the clamp is compiled out.

Function
REQ-015 Subtraction SHALL compute A + ~B + 1 using 4-bit carry-lookahead groups, each producing per-bit generate/propagate and a group carry.
REQ-016 Stage S1 SHALL register the low-half group sums, the carry into the upper half, and the upper operand bits.
REQ-017 Stage S2 SHALL complete the upper groups and compute the following fields:
  - a_lt_b = NOT(final carry out);
  - diff = raw result, or its two's-complement negation when a_lt_b = 1;
  - eq = (raw == 0).
  S2 registers these as the outputs.
REQ-018 Transfer rules:
  - An input transfer occurs when in_valid AND in_ready.
  - An output transfer occurs when out_valid AND out_ready.
  - Latency is exactly 2 cycles from input transfer to out_valid with no stall.
  - Throughput is 1 transfer per cycle.
REQ-019 Ready logic: in_ready = NOT s1_valid OR NOT out_valid OR out_ready (combinational). The pipeline SHALL hold 2 entries with no loss, duplication or reordering under any out_ready pattern.
REQ-020 While out_valid = 1 and out_ready = 0, diff, a_lt_b, eq and sat SHALL hold stable. Inputs sampled without a transfer SHALL be ignored.
REQ-021 Under EXP_SUB_CLAMP_EN:
  - if the magnitude is greater than SHIFT_MAX, diff = SHIFT_MAX and sat = 1;
  - otherwise sat = 0.
REQ-022 Boundary cases:
  - A = 0 and B = max gives diff = max, a_lt_b = 1.
  - Equal operands give diff = 0, eq = 1, a_lt_b = 0.
  - A simultaneous input transfer and output transfer with both stages full SHALL advance both stages in the same cycle.

Reset
REQ-023 When rst_n = 0 at a clock edge: s1_valid = 0, out_valid = 0, diff = 0, a_lt_b = 0, eq = 0, sat = 0. in_ready SHALL read 1 from that edge onward.
REQ-024 Reset mid-operation SHALL discard all in-flight entries. No result SHALL appear for operands accepted before reset.

Configuration
REQ-025 Macro EXP_SUB_CLAMP_EN:
  - defined: clamp logic per REQ-021 is present;
  - undefined: no clamp logic, diff is the full magnitude, sat is tied 0, SHIFT_MAX is unused.
  Latency is identical in both builds.

Structure
REQ-026 Package fp_arith_pkg SHALL contain:
  - constant EXP_W = 8;
  - typedef exp_t (logic [EXP_W-1:0]);
  - constant SHIFT_MAX_DEFAULT = 27;
  - a packed struct cla4_t holding sum[3:0], group generate, group propagate and carry out.
REQ-027 One sub-module, cla4_block, SHALL be the purely combinational 4-bit lookahead group. It is instantiated WIDTH/4 times for the subtract and reused for the negation.

Verification
REQ-028 A=0x85, B=0x80, out_ready=1 -> 2 cycles later out_valid=1, diff=0x05, a_lt_b=0, eq=0, sat=0.
REQ-029 A=0x10, B=0xF0 -> without clamp diff=0xE0, a_lt_b=1, sat=0; with EXP_SUB_CLAMP_EN diff=0x1B, sat=1.
REQ-030 A=B=0x7F -> diff=0x00, eq=1, a_lt_b=0. A=0x10, B=0x01 (borrow crosses nibble) -> diff=0x0F, a_lt_b=0.
REQ-031 Stream 4 back-to-back pairs and hold out_ready=0 for 4 cycles:
  - in_ready drops after 2 transfers;
  - outputs hold stable while stalled;
  - all 4 results emerge in order once out_ready=1.
REQ-032 Drive rst_n=0 for one cycle with 2 entries in flight -> next cycle out_valid=0, in_ready=1, and no stale result ever appears.
REQ-033 A=0x00, B=0xFF -> diff=0xFF, a_lt_b=1; A=0xFF, B=0x00 -> diff=0xFF, a_lt_b=0.
